neuron_mac_acc: RTL and testbench



---
 rtl/nn_pkg.sv | 24 ++
 rtl/sm_mult.sv | 19 +
 rtl/neuron_mac_acc.sv | 96 +++++++++
 tb/tb_neuron_mac_acc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared datapath defaults, FSM state type and sign-magnitude helpers.
package nn_pkg;

    localparam int DW_DEF    = 8;
    localparam int O_VEC_DEF = 21;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

    typedef logic [O_VEC_DEF-1:0] acc_t;

    // A zero magnitude always carries a positive sign.
    function automatic logic sm_norm(input logic s, input logic nonzero);
        return s & nonzero;
    endfunction

    function automatic logic acc_sign(input acc_t v);
        return v[O_VEC_DEF-1];
    endfunction

    function automatic logic [O_VEC_DEF-2:0] acc_mag(input acc_t v);
        return v[O_VEC_DEF-2:0];
    endfunction

endpackage

// File: rtl/sm_mult.sv
// sm_mult: combinational sign-magnitude multiplier, DW-bit operands, O_VEC-bit
// zero-extended product with negative zero folded to +0.
module sm_mult
    import nn_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int O_VEC = O_VEC_DEF
) (
    input  logic [DW-1:0]    x_i,
    input  logic [DW-1:0]    w_i,
    output logic [O_VEC-1:0] p_o
);

    logic [2*(DW-1)-1:0] mag;

    assign mag = {{(DW-1){1'b0}}, x_i[DW-2:0]} * {{(DW-1){1'b0}}, w_i[DW-2:0]};
    assign p_o = {sm_norm(x_i[DW-1] ^ w_i[DW-1], |mag), {(O_VEC-1-2*(DW-1)){1'b0}}, mag};

endmodule

// File: rtl/neuron_mac_acc.sv
// neuron_mac_acc: sequential sign-magnitude MAC for one neuron, N_IN terms in, one sum out.
// Optional NEURON_RELU_EN clamps negative results to zero on out_data_o.
module neuron_mac_acc
    import nn_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int O_VEC = O_VEC_DEF,
    parameter int N_IN  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_x_i,
    input  logic [DW-1:0]    in_w_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [O_VEC-1:0] out_data_o
);

    localparam int CW = $clog2(N_IN + 1);

    state_e           state_q, state_d;
    logic [O_VEC-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [O_VEC-1:0] prod, sum, res;
    logic [O_VEC-2:0] a_m, p_m, s_m;
    logic             a_s, p_s, s_s, ge, xfer;

    sm_mult #(.DW(DW), .O_VEC(O_VEC)) u_mult (
        .x_i(in_x_i),
        .w_i(in_w_i),
        .p_o(prod)
    );

    // Sign-magnitude add of the running sum and the current product.
    always_comb begin
        a_s = acc_q[O_VEC-1];
        p_s = prod[O_VEC-1];
        a_m = acc_q[O_VEC-2:0];
        p_m = prod[O_VEC-2:0];
        ge  = a_m >= p_m;
        s_m = (a_s == p_s) ? a_m + p_m : (ge ? a_m - p_m : p_m - a_m);
        s_s = (a_s == p_s) ? a_s : (ge ? a_s : p_s);
        sum = {sm_norm(s_s, |s_m), s_m};
    end

    assign in_ready_o  = !rst && state_q != DONE;
    assign out_valid_o = state_q == DONE;
    assign xfer        = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (xfer) begin
                acc_d   = prod;
                cnt_d   = CW'(1);
                state_d = (N_IN == 1) ? DONE : ACC;
            end
            ACC: if (xfer) begin
                acc_d   = sum;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(N_IN - 1)) ? DONE : ACC;
            end
            DONE: if (out_ready_i) begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef NEURON_RELU_EN
    assign res = acc_q[O_VEC-1] ? '0 : acc_q;
`else
    assign res = acc_q;
`endif

    assign out_data_o = out_valid_o ? res : '0;

endmodule

// File: tb/tb_neuron_mac_acc.sv
// tb_neuron_mac_acc: scoreboard bench over four instances (N_IN = 4, 2, 64, 1).
module tb_neuron_mac_acc;

    typedef struct {
        int          id;
        logic [20:0] d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       in_valid = '0;
    logic [3:0]       in_ready;
    logic [3:0][7:0]  in_x = '0;
    logic [3:0][7:0]  in_w = '0;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready = '0;
    logic [3:0][20:0] out_data;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        neuron_mac_acc #(
            .DW(8), .O_VEC(21), .N_IN(g == 0 ? 4 : g == 1 ? 2 : g == 2 ? 64 : 1)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .in_valid_i(in_valid[g]),
            .in_ready_o(in_ready[g]),
            .in_x_i(in_x[g]),
            .in_w_i(in_w[g]),
            .out_valid_o(out_valid[g]),
            .out_ready_i(out_ready[g]),
            .out_data_o(out_data[g])
        );
    end

    // Monitor: every completed output handshake must match the next queued result.
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out dut=%0d got=%h", k, out_data[k]);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        if (e.id != k || out_data[k] !== e.d) begin
                            errors++;
                            $display("FAIL scoreboard dut=%0d got=%h exp_dut=%0d exp=%h",
                                     k, out_data[k], e.id, e.d);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [7:0] x, input logic [7:0] w);
        in_valid[k] = v;
        in_x[k]     = x;
        in_w[k]     = w;
        @(negedge clk);
    endtask

    task automatic push(input int k, input logic [20:0] d);
        exp_t e;
        e.id = k;
        e.d  = d;
        q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit [6:0]    pat;
        logic [7:0]  t;
        logic [20:0] exp_relu;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_in_ready", in_ready[k], 0);
            chk("rst_out_valid", out_valid[k], 0);
            chk("rst_out_data", out_data[k], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk("post_rst_in_ready", in_ready[k], 1);

        // -15 + 14 + 1 + 0 cancels to +0
        out_ready[0] = 1'b1;
        push(0, 21'h0);
        drive(0, 1, 8'h03, 8'h85);
        drive(0, 1, 8'h02, 8'h07);
        drive(0, 1, 8'h81, 8'h81);
        chk("t1_not_early", out_valid[0], 0);
        drive(0, 1, 8'h0A, 8'h00);
        in_valid[0] = 1'b0;
        chk("t1_latency", out_valid[0], 1);
        chk("t1_data", out_data[0], 0);
        @(negedge clk);
        chk("t1_idle", out_valid[0], 0);

        // +12 then -12 must give +0, not -0
        out_ready[1] = 1'b1;
        push(1, 21'h0);
        drive(1, 1, 8'h03, 8'h04);
        drive(1, 1, 8'h83, 8'h04);
        in_valid[1] = 1'b0;
        chk("t2_valid", out_valid[1], 1);
        chk("t2_data", out_data[1], 0);
        @(negedge clk);

        // Full-scale sum with a 5-cycle downstream stall
        push(2, 21'd1032256);
        repeat (64) drive(2, 1, 8'h7F, 8'h7F);
        in_valid[2] = 1'b0;
        chk("t3_latency", out_valid[2], 1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_in_ready", in_ready[2], 0);
            chk("t3_stall_valid", out_valid[2], 1);
            chk("t3_stall_data", out_data[2], 32'd1032256);
            @(negedge clk);
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        chk("t3_idle_valid", out_valid[2], 0);
        chk("t3_idle_ready", in_ready[2], 1);
        out_ready[2] = 1'b0;

        // Gapped input: 1+2+3+4
        pat = 7'b1011001;
        t   = 8'd1;
        push(0, 21'd10);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) chk("t4_no_early_valid", out_valid[0], 0);
            drive(0, pat[i], pat[i] ? t : 8'h00, 8'h01);
            if (pat[i]) t = t + 8'd1;
        end
        in_valid[0] = 1'b0;
        chk("t4_valid", out_valid[0], 1);
        @(negedge clk);

        // Reset mid-accumulation discards the partial sum
        drive(0, 1, 8'h01, 8'h01);
        drive(0, 1, 8'h01, 8'h01);
        in_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_in_ready", in_ready[0], 0);
        chk("t5_rst_out_valid", out_valid[0], 0);
        chk("t5_rst_out_data", out_data[0], 0);
        rst = 1'b0;
        push(0, 21'd4);
        repeat (4) drive(0, 1, 8'h01, 8'h01);
        in_valid[0] = 1'b0;
        chk("t5_valid", out_valid[0], 1);
        chk("t5_data", out_data[0], 32'd4);
        @(negedge clk);

        // Single-term neuron, negative product
`ifdef NEURON_RELU_EN
        exp_relu = 21'h0;
`else
        exp_relu = 21'h100006;
`endif
        out_ready[3] = 1'b1;
        push(3, exp_relu);
        drive(3, 1, 8'h82, 8'h03);
        in_valid[3] = 1'b0;
        chk("t6_valid", out_valid[3], 1);
        chk("t6_data", out_data[3], {11'b0, exp_relu});
        @(negedge clk);
        chk("t6_idle", out_valid[3], 0);

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
